// File: rtl/cdc_rx_ctrl.sv
// ---------------------------------------------------------------------------
// cdc_rx_ctrl
//
// Receive-side controller for a 4-phase req/ack crossing into the clk domain.
// The foreign request is synchronised through a SYNC_DEPTH flop chain. The
// sender-held data word is sampled once in CAPTURE and then presented on a
// valid/ready interface. A registered acknowledge goes back to the sender, and
// completed consumer handshakes are counted.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous assert, active-low reset
//   async_req   in   4-phase request level from the foreign domain
//   async_data  in   sender data, stable from req rise until ack rise
//   ack         out  registered acknowledge to the sender
//   out_data    out  captured word
//   out_valid   out  out_data holds an unconsumed word
//   out_ready   in   consumer accepts when high together with out_valid
//   err_clr     in   single-cycle clear of proto_err
//   proto_err   out  sticky protocol-violation flag
//   xfer_cnt    out  completed handshakes, wraps silently
// ---------------------------------------------------------------------------
module cdc_rx_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int SYNC_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  async_req,
    input  logic [DATA_WIDTH-1:0] async_data,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  err_clr,
    output logic                  proto_err,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    // A single-stage synchroniser gives no metastability settling time.
    generate
        if (SYNC_DEPTH < 2) begin : g_bad_depth
            $error("cdc_rx_ctrl: SYNC_DEPTH must be 2 or greater");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_HOLD,
        ST_ACK_WAIT
    } state_t;

    state_t                state_reg, state_next;
    logic [SYNC_DEPTH-1:0] sync_chain_reg;
    logic                  sync_req;
    logic                  ack_reg, ack_next;
    logic                  out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic                  proto_err_reg, proto_err_next;
    logic [CNT_WIDTH-1:0]  xfer_cnt_reg, xfer_cnt_next;
    logic                  violation;

    // Request synchroniser: bit 0 takes the raw level, the top bit is the
    // only one the FSM is allowed to look at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain_reg <= '0;
        end else begin
            sync_chain_reg <= {sync_chain_reg[SYNC_DEPTH-2:0], async_req};
        end
    end

    assign sync_req = sync_chain_reg[SYNC_DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ack_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            proto_err_reg <= 1'b0;
            xfer_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            ack_reg       <= ack_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            proto_err_reg <= proto_err_next;
            xfer_cnt_reg  <= xfer_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ack_next       = ack_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        xfer_cnt_next  = xfer_cnt_reg;
        violation      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (sync_req) begin
                    state_next = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                // async_data is safe to sample here: the sender holds it
                // until it sees ack, and ack is still low.
                out_data_next  = async_data;
                out_valid_next = 1'b1;
                state_next     = ST_HOLD;
                violation      = ~sync_req;
            end

            ST_HOLD: begin
                // A request withdrawn before ack is flagged, but the word
                // already captured is still delivered and acknowledged.
                violation = ~sync_req;
                if (out_valid_reg && out_ready) begin
                    out_valid_next = 1'b0;
                    ack_next       = 1'b1;
                    xfer_cnt_next  = xfer_cnt_reg + 1'b1;
                    state_next     = ST_ACK_WAIT;
                end
            end

            ST_ACK_WAIT: begin
                if (!sync_req) begin
                    ack_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A fresh violation takes priority over a coincident clear.
        if (violation) begin
            proto_err_next = 1'b1;
        end else if (err_clr) begin
            proto_err_next = 1'b0;
        end else begin
            proto_err_next = proto_err_reg;
        end
    end

    assign ack       = ack_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign proto_err = proto_err_reg;
    assign xfer_cnt  = xfer_cnt_reg;

endmodule

// File: doc/cdc_rx_ctrl.md
# cdc_rx_ctrl

Receive-side controller for a 4-phase req/ack clock-domain crossing into the `clk` domain. It synchronises the incoming request through an internal flop chain, captures the sender-held data word, and presents it on a valid/ready interface. It returns a registered acknowledge to the sender and counts completed transfers. It sits between an asynchronous requester (for example a host or PHY-side interface) and the local memory-control datapath.

## Interface
- `DATA_WIDTH`, default 32: width of transferred word.
- `SYNC_DEPTH`, default 2: request synchroniser stages; must be 2 or greater (elaboration error otherwise).
- `CNT_WIDTH`, default 16: width of transfer counter.

Ports:
- `clk`  in  1: the single clock; all flops are rising-edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low; deassertion is synchronised to `clk` upstream.
- `async_req`  in  1: request from the foreign domain; 4-phase level.
- `async_data`  in  DATA_WIDTH: sender data, held stable from `async_req` rise until `ack` rise.
- `ack`  out  1: registered acknowledge to the sender.
- `out_data`  out  DATA_WIDTH: captured word.
- `out_valid`  out  1: `out_data` holds an unconsumed word.
- `out_ready`  in  1: consumer accepts the word when high together with `out_valid`.
- `err_clr`  in  1: single-cycle clear of `proto_err`.
- `proto_err`  out  1: sticky protocol-violation flag.
- `xfer_cnt`  out  CNT_WIDTH: count of completed consumer handshakes; wraps.

## Operation
- Synchroniser: `async_req` passes through a SYNC_DEPTH-stage flop chain. The last stage is `sync_req`. `async_data` is never synchronised; it is sampled only in CAPTURE, relying on the sender's hold guarantee.
- FSM states: IDLE, CAPTURE, HOLD, ACK_WAIT.
  - IDLE: `sync_req`=1 -> CAPTURE.
  - CAPTURE: `out_data` <= `async_data`, `out_valid` <= 1 -> HOLD.
  - HOLD: when `out_valid` && `out_ready`, then `out_valid` <= 0, `ack` <= 1, `xfer_cnt` <= `xfer_cnt`+1 (mod 2^CNT_WIDTH) -> ACK_WAIT. Otherwise hold. `out_data` is stable throughout.
  - ACK_WAIT: `sync_req`=0 -> `ack` <= 0 -> IDLE.
- Protocol error: `sync_req`=0 observed in CAPTURE or HOLD sets `proto_err`. The FSM flow is otherwise unchanged: the captured word is still delivered and acked, and ACK_WAIT exits on the next cycle if `req` is still low.
- `err_clr` clears `proto_err`. If `err_clr` and a new violation occur in the same cycle, set wins.
- `out_valid` never drops without a handshake, except on reset.
- Reset mid-transfer: all state is lost. If `async_req` is still high after release, the word is recaptured and delivered again. Duplicate delivery across reset is accepted behaviour.

## Timing
- Reset values: `ack`=0, `out_valid`=0, `out_data`=0, `proto_err`=0, `xfer_cnt`=0. The sync chain is all 0 and the FSM is in IDLE.
- Request to valid: with `async_req` first sampled high at edge E0, `sync_req` is high after edge E0+SYNC_DEPTH-1. `out_valid` rises after edge E0+SYNC_DEPTH+1, which is SYNC_DEPTH+2 edges including E0.
- Valid to ack: `ack` rises at the same edge that completes the `out_valid`/`out_ready` handshake. `out_ready` held high gives a 1-cycle HOLD dwell.
- Ack release: `ack` falls at the edge after `sync_req` is observed 0 in ACK_WAIT. `async_req` fall to `ack` fall is SYNC_DEPTH+1 edges.
- Minimum full-cycle period, with `out_ready` held high and the sender reacting in zero time: 2·SYNC_DEPTH+4 clocks per word.
- `xfer_cnt` updates on the handshake edge. It wraps from 2^CNT_WIDTH-1 to 0 without flagging.
- No combinational path exists from any input to any output.

## Test plan
- Reset: assert `rst_n`=0 with random inputs -> all outputs read their reset values immediately (async), and remain so until release.
- Single transfer, SYNC_DEPTH=2, `out_ready`=1: raise `async_req` with `async_data`=0xDEADBEEF -> `out_valid` high 4 edges later with `out_data`=0xDEADBEEF, `ack` high one edge after that. Drop `req` -> `ack` low 3 edges later; `xfer_cnt`=1.
- Backpressure: `out_ready`=0 for 10 cycles after valid -> `out_valid`/`out_data` stable and `ack`=0. Then raise `out_ready` -> `ack` rises on the handshake edge.
- Back-to-back 1000 random words, SYNC_DEPTH=3, random `out_ready` -> words delivered in order with no loss or duplication, and `xfer_cnt`=1000.
- Protocol error: drop `async_req` while in HOLD -> `proto_err`=1, word still delivered, FSM returns to IDLE. Then `err_clr` coincident with a fresh violation -> `proto_err` stays 1.
- Wrap and reset: CNT_WIDTH=4, 17 transfers -> `xfer_cnt`=1. Assert `rst_n` in HOLD with `req` held -> `ack`=0 at once, and the same word is redelivered after release.
